router_1xn: RTL and testbench
=============================

# router_1xn

Parametrised packet router: one byte-stream input, `N_CH` output channels, each with its own FIFO. It replaces the fixed 1x3 router in the packet path. Destination decode, parity check, stuck-reader timeout and invalid-address drop are handled in one FSM; channel count, data width, FIFO depth and timeout are parameters.

## Interface

- `DATA_W`, 8: byte width; header `[ADDR_W-1:0]` = destination, rest = length (informational only)
- `N_CH`, 3: output channels, 2..16; `ADDR_W = clog2(N_CH)`, minimum 1
- `DEPTH`, 16: entries per channel FIFO, power of 2
- `TIMEOUT`, 30: cycles a channel may be valid-but-unread before it is flushed
- `clk` in 1: single clock; all state on rising edge
- `reset` in 1: synchronous, active-high
- `pkt_valid` in 1: high during header and payload; the first low cycle after a packet carries the parity byte
- `data_in` in DATA_W: header/payload/parity byte
- `busy` out 1: source must hold `data_in`/`pkt_valid` while high
- `read_enb` in N_CH: per-channel read strobe
- `vld_out` out N_CH: `~empty` per channel
- `data_out` out N_CH*DATA_W: channel i at `[i*DATA_W +: DATA_W]`
- `err` out 1: one-cycle parity-mismatch pulse
- `drop` out 1: one-cycle pulse when an invalid-address packet ends

## Operation

- **Reset values:** all outputs 0, FIFOs empty, FSM in IDLE, parity accumulator 0, timeout counters 0.
- **FSM states:**
  - IDLE (busy=0): on `pkt_valid`, capture header and `dest`, set parity = header. If `dest>=N_CH`, go to DROP. Else if `empty[dest]`, go to WRITE_HDR; else go to WAIT_EMPTY.
  - WAIT_EMPTY (busy=1): go to WRITE_HDR when `empty[dest]`.
  - WRITE_HDR (busy=1): write header with the first-byte marker set; go to LOAD_DATA.
  - LOAD_DATA (busy=`full[dest]`):
    - `pkt_valid & ~full`: write `data_in`, parity ^= `data_in`.
    - `~pkt_valid & ~full`: write the parity byte, compare, go to CHECK.
    - `full`: no write; stay.
  - CHECK (busy=1): register `err` = (accumulated parity != parity byte); go to IDLE.
  - DROP (busy=0): discard input until the first `pkt_valid`=0 cycle (the parity byte is consumed), pulse `drop`, go to IDLE.
- **FIFO:**
  - Entries are `DATA_W+1` bits: data plus first-byte marker. The marker is stored but is not visible on `data_out`.
  - Full when count==`DEPTH`; all `DEPTH` entries are usable. Pointers wrap modulo `DEPTH`.
  - A write is accepted iff `~full`. A read is accepted iff `read_enb & ~empty`. Simultaneous write and read both occur and count is unchanged.
  - `full` is derived from the registered count, so a read in the same cycle does not unblock a write.
  - `data_out` updates only on an accepted read; otherwise it holds.
- **Timeout:**
  - Per channel: counter increments while `vld_out & ~read_enb`, and clears otherwise.
  - On reaching `TIMEOUT`, pulse the channel soft reset: FIFO pointers and count cleared, counter cleared, `data_out` holds its last value.
  - If the flushed channel is `dest` and the FSM is in WAIT_EMPTY/WRITE_HDR/LOAD_DATA, the FSM goes to DROP, suppressing `drop` and `err` for that packet.
- **Reset mid-packet:** everything returns to reset values next cycle. The source must restart the packet.

## Timing

- Header accepted at cycle T with `dest` empty: header written at end of T+1; `vld_out[dest]` high at T+2.
- Read latency is 1: `read_enb` at cycle R gives `data_out` valid at R+1.
- A payload byte present while busy=0 in LOAD_DATA is written that cycle. The first payload byte is held by the source from T+1 until busy falls (T+2 if the destination was empty).
- `err` is high exactly one cycle, the cycle after the parity byte is written. `drop` is high exactly one cycle, the cycle after the parity byte is consumed in DROP.
- Soft reset takes effect the cycle after the counter reaches `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after `vld_out` rose with no read.

## Structure

- Package `router_pkg`: FSM state encoding, the `clog2` function, and the FIFO entry layout constants (`MARK_BIT = DATA_W`).
- Sub-module `router_chan_fifo` (`DATA_W`, `DEPTH`, `TIMEOUT`): storage, pointers, count, full/empty, read register, timeout counter and soft reset. It is instantiated `N_CH` times via generate.
- Top level holds the FSM, header/parity registers, and write-enable decode.

## Test plan

Defaults for all scenarios: `N_CH`=3, `DATA_W`=8, `DEPTH`=16, `TIMEOUT`=30.

- **Good packet:** header 8'h0D, payload 11/22/33, parity 8'h0D. Channel 1 reads 0D,11,22,33,0D; `err` stays 0; `vld_out[0]` and `vld_out[2]` stay 0.
- **Bad parity:** same packet with parity 8'h00. `err` pulses exactly one cycle; all 5 bytes are still delivered to channel 1.
- **Invalid address:** header 8'h0F (dest 3), 2 payload bytes, parity. No FIFO writes; busy stays 0; `drop` pulses once; the next valid packet routes normally.
- **Backpressure:** 20-byte payload to channel 0, no reads. Busy goes high once 16 entries are stored. Each single read lets exactly one byte in. The full 22-byte stream is read in order.
- **Timeout:** packet to channel 2, `read_enb`=0 for 31 cycles. `vld_out[2]` falls. A new packet to channel 2 then goes IDLE→WRITE_HDR without waiting.
- **Reset mid-payload:** assert `reset` during LOAD_DATA. The next cycle shows all `vld_out`=0, busy=0, `err`=0; a fresh packet routes correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN packet router.
package router_pkg;

  // Router control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_EMPTY = 3'd1,
    ST_WRITE_HDR  = 3'd2,
    ST_LOAD_DATA  = 3'd3,
    ST_CHECK      = 3'd4,
    ST_DROP       = 3'd5
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // FIFO entry layout: data in the low bits, first-byte marker on top.
  function automatic int unsigned mark_bit(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/router_chan_fifo.sv
// One output channel: FIFO storage, read register and stuck-reader flush.
module router_chan_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W:0]   wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              vld,
  output logic              full,
  output logic              flush_c
);

  localparam int unsigned PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned TMO_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [TMO_W-1:0]   tmo_q;
  logic               wr_ok_c;
  logic               rd_ok_c;

  // Accept decode, flush request and next occupancy.
  always_comb begin
    wr_ok_c = wr_en & ~full;
    rd_ok_c = rd_en & vld;
    flush_c = (tmo_q == TMO_W'(TIMEOUT));
    count_d = count_q;
    if (wr_ok_c && !rd_ok_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_ok_c && !wr_ok_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Entry storage; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy flags, read register and stuck-reader counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      vld      <= 1'b0;
      tmo_q    <= '0;
      data_out <= '0;
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      vld      <= 1'b0;
      tmo_q    <= '0;
    end else begin
      if (wr_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        data_out <= mem[rd_ptr_q][DATA_W-1:0];
      end
      count_q <= count_d;
      full    <= (count_d == CNT_W'(DEPTH));
      vld     <= (count_d != '0);
      if (vld && !rd_en) tmo_q <= tmo_q + TMO_W'(1);
      else               tmo_q <= '0;
    end
  end

endmodule

// File: rtl/router_1xn.sv
// 1xN packet router: header decode, parity check, drop and flush handling.
module router_1xn
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_CH    = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     busy,
  input  logic [N_CH-1:0]          read_enb,
  output logic [N_CH-1:0]          vld_out,
  output logic [N_CH*DATA_W-1:0]   data_out,
  output logic                     err,
  output logic                     drop
);

  localparam int unsigned ADDR_W   = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
  localparam int unsigned ADDR_W1  = ADDR_W + 1;
  localparam int unsigned N_PAD    = 32'd1 << ADDR_W;
  localparam int unsigned ENTRY_W  = entry_w(DATA_W);
  localparam int unsigned MARK_BIT = mark_bit(DATA_W);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   dest_q;
  logic [DATA_W-1:0]   hdr_q;
  logic [DATA_W-1:0]   par_q;
  logic                quiet_q;

  logic [ADDR_W-1:0]   dest_in_c;
  logic                dest_bad_c;
  logic                flush_hit_c;
  logic                busy_c;
  logic                wr_sel_c;
  logic [ENTRY_W-1:0]  wr_data_c;
  logic                err_d;
  logic                drop_d;

  logic [N_CH-1:0]     full_vec;
  logic [N_CH-1:0]     flush_vec;
  logic [N_CH-1:0]     wr_en_vec;
  logic [N_PAD-1:0]    full_pad;
  logic [N_PAD-1:0]    vld_pad;
  logic [N_PAD-1:0]    flush_pad;

  // Channel status widened to the full address space; unused slots read idle.
  always_comb begin
    full_pad            = '0;
    vld_pad             = '0;
    flush_pad           = '0;
    full_pad[N_CH-1:0]  = full_vec;
    vld_pad[N_CH-1:0]   = vld_out;
    flush_pad[N_CH-1:0] = flush_vec;
  end

  // Header address decode and flush of the channel owned by the packet.
  always_comb begin
    dest_in_c   = data_in[ADDR_W-1:0];
    dest_bad_c  = ({1'b0, dest_in_c} >= ADDR_W1'(N_CH));
    flush_hit_c = flush_pad[dest_q] &
                  ((state_q == ST_WAIT_EMPTY) || (state_q == ST_WRITE_HDR) ||
                   (state_q == ST_LOAD_DATA));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; a flush of the destination abandons the packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pkt_valid) begin
          if (dest_bad_c)              state_d = ST_DROP;
          else if (!vld_pad[dest_in_c]) state_d = ST_WRITE_HDR;
          else                          state_d = ST_WAIT_EMPTY;
        end
      end
      ST_WAIT_EMPTY: if (!vld_pad[dest_q]) state_d = ST_WRITE_HDR;
      ST_WRITE_HDR:  state_d = ST_LOAD_DATA;
      ST_LOAD_DATA:  if (!full_pad[dest_q] && !pkt_valid) state_d = ST_CHECK;
      ST_CHECK:      state_d = ST_IDLE;
      ST_DROP:       if (!pkt_valid) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    if (flush_hit_c) state_d = ST_DROP;
  end

  // FSM outputs: busy, FIFO write select/data and the err/drop pulse requests.
  always_comb begin
    busy_c                   = 1'b0;
    wr_sel_c                 = 1'b0;
    wr_data_c                = '0;
    wr_data_c[DATA_W-1:0]    = data_in;
    err_d                    = 1'b0;
    drop_d                   = 1'b0;
    case (state_q)
      ST_WAIT_EMPTY: busy_c = 1'b1;
      ST_WRITE_HDR: begin
        busy_c                = 1'b1;
        wr_sel_c              = 1'b1;
        wr_data_c[DATA_W-1:0] = hdr_q;
        wr_data_c[MARK_BIT]   = 1'b1;
      end
      ST_LOAD_DATA: begin
        busy_c   = full_pad[dest_q];
        wr_sel_c = ~full_pad[dest_q];
        err_d    = ~full_pad[dest_q] & ~pkt_valid & (par_q != data_in) & ~flush_hit_c;
      end
      ST_CHECK:  busy_c = 1'b1;
      ST_DROP:   drop_d = ~pkt_valid & ~quiet_q;
      default:   busy_c = 1'b0;
    endcase
  end

  assign busy = busy_c;

  // Header, destination, running parity and the registered err/drop pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q   <= '0;
      dest_q  <= '0;
      par_q   <= '0;
      quiet_q <= 1'b0;
      err     <= 1'b0;
      drop    <= 1'b0;
    end else begin
      err  <= err_d;
      drop <= drop_d;
      if ((state_q == ST_IDLE) && pkt_valid) begin
        hdr_q   <= data_in;
        dest_q  <= dest_in_c;
        par_q   <= data_in;
        quiet_q <= 1'b0;
      end else if ((state_q == ST_LOAD_DATA) && pkt_valid && !full_pad[dest_q]) begin
        par_q <= par_q ^ data_in;
      end
      if (flush_hit_c) quiet_q <= 1'b1;
    end
  end

  // Per-channel write decode and FIFO instances.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign wr_en_vec[i] = wr_sel_c & (dest_q == ADDR_W'(i));

    router_chan_fifo #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_vec[i]),
      .wr_data  (wr_data_c),
      .rd_en    (read_enb[i]),
      .data_out (data_out[i*DATA_W +: DATA_W]),
      .vld      (vld_out[i]),
      .full     (full_vec[i]),
      .flush_c  (flush_vec[i])
    );
  end

endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn with hand-computed expected bytes.
module tb_router_1xn;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned N_CH    = 3;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 30;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pkt_valid;
  logic [DATA_W-1:0]      data_in;
  logic                   busy;
  logic [N_CH-1:0]        read_enb;
  logic [N_CH-1:0]        vld_out;
  logic [N_CH*DATA_W-1:0] data_out;
  logic                   err;
  logic                   drop;

  router_1xn #(
    .DATA_W  (DATA_W),
    .N_CH    (N_CH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .busy      (busy),
    .read_enb  (read_enb),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .err       (err),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned err_cnt = 0, drop_cnt = 0, busy_cnt = 0, side_cnt = 0, vld_cnt = 0;
  int unsigned src_cnt;
  int unsigned hdr_cyc;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (err)                      err_cnt  <= err_cnt + 1;
    if (drop)                     drop_cnt <= drop_cnt + 1;
    if (busy)                     busy_cnt <= busy_cnt + 1;
    if (vld_out[0] | vld_out[2])  side_cnt <= side_cnt + 1;
    if (|vld_out)                 vld_cnt  <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive tx_q (header, payload..., parity) honouring busy.
  task automatic send_pkt();
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    while (idx < tx_q.size() && budget < 400) begin
      @(negedge clk);
      data_in   = tx_q[idx];
      pkt_valid = (idx < tx_q.size() - 1);
      if (!busy) begin
        if (idx == 0) hdr_cyc = cyc;
        idx++;
        src_cnt++;
      end
      budget++;
    end
    check("src_done", 32'(idx), 32'(tx_q.size()));
    @(negedge clk);
    pkt_valid = 1'b0;
    data_in   = '0;
  endtask

  // Read rx_q.size() bytes from channel ch and compare in order.
  task automatic recv_chk(input int ch);
    int n;
    @(negedge clk);
    for (int k = 0; k < rx_q.size(); k++) begin
      n = 0;
      while (!vld_out[ch] && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!vld_out[ch]) begin
        check($sformatf("rx%0d_wait%0d", ch, k), 32'(vld_out[ch]), 32'd1);
        return;
      end
      read_enb[ch] = 1'b1;
      @(negedge clk);
      read_enb[ch] = 1'b0;
      check($sformatf("rx%0d_b%0d", ch, k), 32'(data_out[ch*DATA_W +: DATA_W]), 32'(rx_q[k]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned e0, d0, b0, s0, v0;
    int n;
    reset     = 1'b1;
    pkt_valid = 1'b0;
    data_in   = '0;
    read_enb  = '0;
    src_cnt   = 0;
    hdr_cyc   = 0;
    repeat (3) @(negedge clk);
    check("rst_vld",  32'(vld_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good packet to channel 1.
    e0 = err_cnt; s0 = side_cnt;
    tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    rx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    fork send_pkt(); recv_chk(1); join
    repeat (3) @(negedge clk);
    check("good_err",  err_cnt - e0, 32'd0);
    check("good_side", side_cnt - s0, 32'd0);

    // Same packet with bad parity byte.
    e0 = err_cnt;
    tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    rx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    fork send_pkt(); recv_chk(1); join
    repeat (3) @(negedge clk);
    check("bad_err_pulse", err_cnt - e0, 32'd1);

    // Invalid destination 3, then a normal packet.
    b0 = busy_cnt; v0 = vld_cnt; d0 = drop_cnt;
    tx_q = '{8'h0F, 8'hAA, 8'hBB, 8'h1E};
    send_pkt();
    repeat (3) @(negedge clk);
    check("inv_busy", busy_cnt - b0, 32'd0);
    check("inv_vld",  vld_cnt - v0, 32'd0);
    check("inv_drop", drop_cnt - d0, 32'd1);
    tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    rx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    fork send_pkt(); recv_chk(1); join
    repeat (2) @(negedge clk);

    // Backpressure: 20-byte payload into channel 0.
    tx_q = {};
    tx_q.push_back(8'h50);
    for (int i = 1; i <= 20; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h44);
    rx_q = {};
    for (int i = 1; i <= 20; i++) rx_q.push_back(8'(i));
    rx_q.push_back(8'h44);
    src_cnt = 0;
    fork
      send_pkt();
      begin
        n = 0;
        while (src_cnt < 2 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        check("bp_busy_rise", 32'(busy), 32'd1);
        check("bp_fill", src_cnt, 32'd16);
        read_enb[0] = 1'b1;
        @(negedge clk);
        read_enb[0] = 1'b0;
        check("bp_rd_hdr", 32'(data_out[7:0]), 32'h50);
        check("bp_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        check("bp_busy_back", 32'(busy), 32'd1);
        check("bp_one_in", src_cnt, 32'd17);
        recv_chk(0);
      end
    join
    repeat (3) @(negedge clk);
    check("bp_hold", 32'(data_out[7:0]), 32'h44);

    // Timeout flush of unread channel 2.
    tx_q = '{8'h0A, 8'h5A, 8'hA5, 8'hF5};
    fork
      send_pkt();
      begin
        n = 0;
        while (!vld_out[2] && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (vld_out[2] && n < 100) begin n++; @(negedge clk); end
        check("tmo_len", 32'(n), 32'(TIMEOUT + 1));
      end
    join
    check("tmo_vld", 32'(vld_out), 32'd0);
    hdr_cyc = 0;
    tx_q = '{8'h06, 8'h77, 8'h71};
    fork
      send_pkt();
      begin
        n = 0;
        while (!vld_out[2] && n < 100) begin @(negedge clk); n++; end
        check("tmo_no_wait", cyc - hdr_cyc, 32'd2);
      end
    join
    rx_q = '{8'h06, 8'h77, 8'h71};
    recv_chk(2);
    repeat (2) @(negedge clk);

    // Reset during payload load.
    e0 = err_cnt;
    @(negedge clk); data_in = 8'h0D; pkt_valid = 1'b1;
    @(negedge clk); data_in = 8'h11;
    @(negedge clk); data_in = 8'h11;
    @(negedge clk); data_in = 8'h22;
    check("rst_pre_vld", 32'(vld_out[1]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstm_vld",  32'(vld_out), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_err",  32'(err), 32'd0);
    reset     = 1'b0;
    pkt_valid = 1'b0;
    data_in   = '0;
    @(negedge clk);
    tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    rx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    fork send_pkt(); recv_chk(1); join
    repeat (3) @(negedge clk);
    check("rstm_err_cnt", err_cnt - e0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
